spi_host_loader: RTL and testbench
==================================

// Module: spi_host_loader
// PURPOSE
//  Host-side SPI initiator for the command/data loader link (SPI mode 0, MSB first, plus a DC line).
//  Takes {dc, byte} requests on a valid/ready interface and shifts each one out on MOSI.
//  Captures MISO in parallel and returns one rx byte per tx byte.
//  Drives command bytes (DC=0) and data bytes (DC=1) for IRAM/DRAM load and readback from a host or debug master.
// PARAMETERS
//  CLK_DIV  4   clk_i cycles per SCLK half-period; legal range >=1
//  GAP_CYC  16  idle cycles in GAP before CS deasserts; 0 = deassert on the next cycle
// PORTS
//  clk_i        in   1  system clock
//  rst_n_i      in   1  asynchronous reset, active-low
//  tx_vld_i     in   1  request valid
//  tx_dc_i      in   1  0 = command byte, 1 = data byte
//  tx_data_i    in   8  byte to send
//  tx_rdy_o     out  1  request accepted when tx_vld_i & tx_rdy_o
//  rx_vld_o     out  1  one-cycle pulse: rx_data_o holds a new byte
//  rx_data_o    out  8  MISO byte captured during the last transfer
//  busy_o       out  1  equals ~spi_cs_n_o
//  spi_sclk_o   out  1  SPI clock, idle low
//  spi_cs_n_o   out  1  chip select, active-low
//  spi_dc_o     out  1  data/command line, stable for the whole byte
//  spi_mosi_o   out  1  serial data out
//  spi_miso_i   in   1  serial data in, synchronous to clk_i
// BEHAVIOUR
//  Reset values (async, effective immediately):
//   - cs_n=1, sclk=0, mosi=0, dc=0, rx_vld=0, rx_data=0, busy=0.
//   - State IDLE; tx_rdy_o=1, decoded from state.
//  FSM states: IDLE, SHIFT, GAP. tx_rdy_o=1 only in IDLE and GAP.
//  Accept, on cycle T with tx_vld_i & tx_rdy_o:
//   - Latch tx_data_i and tx_dc_i.
//   - At T+1: cs_n=0, dc=tx_dc_i, mosi=data[7], bit_cnt=0, div_cnt=0; go to SHIFT.
//   - tx_data_i and tx_dc_i are ignored while tx_rdy_o=0.
//  SHIFT timing:
//   - Each bit has a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles.
//   - The low phase of bit 0 serves as the CS-to-SCLK setup time.
//   - Rising SCLK edge: shift spi_miso_i into the rx shift register (LSB in).
//   - Falling SCLK edge for bits 0..6: mosi <= next bit.
//  End of byte:
//   - 8th falling edge at T+1+16*CLK_DIV.
//   - Same cycle: rx_vld_o=1 for exactly one cycle, rx_data_o=captured byte; state -> GAP.
//  GAP:
//   - cs_n stays 0, sclk=0, gap counter runs.
//   - Accept in GAP: reload the byte and dc, enter SHIFT next cycle. CS stays low; no extra setup beyond the bit-0 low phase.
//   - No accept within GAP_CYC cycles: cs_n<=1, mosi<=0, state -> IDLE.
//  DC rules:
//   - spi_dc_o changes only at byte load, with sclk low.
//   - Mixing command and data bytes in one CS frame is legal.
//  Acceptance in IDLE and in GAP on the last gap cycle are handled identically. The accept wins over the timeout: CS stays low.
//  Counters:
//   - div_cnt is $clog2(CLK_DIV)+1 bits and wraps to 0 at CLK_DIV-1.
//   - bit_cnt is 3 bits.
//   - No byte is ever lost or duplicated.
//  Reset mid-byte: the partial transfer is aborted, no rx_vld is issued for it, and all outputs take reset values at once.
// TESTING (CLK_DIV=2, GAP_CYC=4, MISO looped back from MOSI unless stated)
//  1 Reset -> cs_n=1, sclk=0, mosi=0, dc=0, rx_vld=0, busy=0, tx_rdy=1.
//  2 Send dc=0, 0x2C at T:
//     - Required: cs_n falls at T+1; MOSI bits 0,0,1,0,1,1,0,0 at the 8 rising edges; dc=0 throughout.
//     - Required: single rx_vld pulse at T+33 with rx_data=0x2C; cs_n rises 4 cycles later.
//  3 Send dc=0 0x2E, then dc=1 0x12 and 0x34, each presented as soon as tx_rdy=1:
//     - Required: cs_n stays low across all 3 bytes; dc changes only while sclk=0.
//     - Required: rx_vld pulses carry 0x2E, 0x12, 0x34.
//  4 Second byte presented 9 cycles after the first rx_vld -> cs_n high for >=1 cycle between frames, then a normal second frame.
//  5 Hold tx_vld with 0xA5 during a shift, changing tx_data_i to 0x5A while tx_rdy=0:
//     - Required: accepted only in GAP, value seen at accept is sent, sent exactly once.
//  6 MISO driven 0xF0 (not looped), send 0x00 -> rx_data=0xF0. Assert reset after 3 rising edges -> immediate reset values, no rx_vld; next 0x2B transfers cleanly.

Source files
------------

// File: rtl/spi_host_loader_if.sv
// spi_host_loader_if: byte request/response handshake between a host and spi_host_loader
interface spi_host_loader_if;
    logic       tx_vld;
    logic       tx_dc;
    logic [7:0] tx_data;
    logic       tx_rdy;
    logic       rx_vld;
    logic [7:0] rx_data;
    modport master(output tx_vld, tx_dc, tx_data, input tx_rdy, rx_vld, rx_data);
    modport slave(input tx_vld, tx_dc, tx_data, output tx_rdy, rx_vld, rx_data);
endinterface

// File: rtl/spi_host_loader.sv
// spi_host_loader: SPI mode-0 host initiator with DC line, one rx byte returned per tx byte
module spi_host_loader #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    spi_host_loader_if.slave bus,
    output logic             busy_o,
    output logic             spi_sclk_o,
    output logic             spi_cs_n_o,
    output logic             spi_dc_o,
    output logic             spi_mosi_o,
    input  logic             spi_miso_i
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP_CYC + 1) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr, rx_sr;
    logic          accept, tick, rise, fall, last_bit, gap_done;

    assign bus.tx_rdy = state != SHIFT;
    assign accept     = bus.tx_vld && bus.tx_rdy;
    assign tick       = div_cnt == DW'(CLK_DIV - 1);
    assign rise       = state == SHIFT && tick && !spi_sclk_o;
    assign fall       = state == SHIFT && tick && spi_sclk_o;
    assign last_bit   = bit_cnt == 3'd7;
    assign gap_done   = int'(gap_cnt) + 1 >= GAP_CYC;
    assign busy_o     = ~spi_cs_n_o;
    assign spi_mosi_o = tx_sr[7];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else state <= state_nxt;
    end

    // an accept in GAP takes priority over the gap timeout, keeping CS low
    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = SHIFT;
        else if (fall && last_bit) state_nxt = GAP;
        else if (state == GAP && gap_done) state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            spi_cs_n_o  <= 1'b1;
            spi_sclk_o  <= 1'b0;
            spi_dc_o    <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            bus.rx_vld  <= 1'b0;
            bus.rx_data <= '0;
        end else begin
            bus.rx_vld <= 1'b0;
            if (accept) begin
                tx_sr      <= bus.tx_data;
                spi_dc_o   <= bus.tx_dc;
                spi_cs_n_o <= 1'b0;
                spi_sclk_o <= 1'b0;
                div_cnt    <= '0;
                bit_cnt    <= '0;
                gap_cnt    <= '0;
            end else if (state == SHIFT) begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
                if (tick) spi_sclk_o <= ~spi_sclk_o;
                if (rise) rx_sr <= {rx_sr[6:0], spi_miso_i};
                if (fall) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (!last_bit) tx_sr <= {tx_sr[6:0], 1'b0};
                    if (last_bit) begin
                        bus.rx_vld  <= 1'b1;
                        bus.rx_data <= rx_sr;
                    end
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
                if (gap_done) begin
                    spi_cs_n_o <= 1'b1;
                    tx_sr      <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_host_loader.sv
// tb_spi_host_loader: directed checks of spi_host_loader with CLK_DIV=2, GAP_CYC=4
module tb_spi_host_loader;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b1;
    logic busy_o, spi_sclk_o, spi_cs_n_o, spi_dc_o, spi_mosi_o, spi_miso_i;
    logic loop = 1'b1;
    logic [7:0] miso_pat = 8'h00;
    logic [2:0] ridx;
    logic [7:0] mosi_sr = 8'h00;
    logic [7:0] rx_log [0:31];
    logic dc_prev = 1'b0;
    int rise_cnt = 0, rx_cnt = 0, cs_rise = 0, dc_bad = 0;
    int n_chk = 0, n_fail = 0;
    int rise_base, rx_base, cs_base, n;

    spi_host_loader_if bus();

    spi_host_loader #(.CLK_DIV(2), .GAP_CYC(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus), .busy_o(busy_o),
        .spi_sclk_o(spi_sclk_o), .spi_cs_n_o(spi_cs_n_o), .spi_dc_o(spi_dc_o),
        .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i)
    );

    always #5 clk_i = ~clk_i;

    // external MISO pattern is presented MSB first, indexed by rising edges seen so far
    assign ridx = 3'd7 - rise_cnt[2:0];
    assign spi_miso_i = loop ? spi_mosi_o : miso_pat[ridx];

    always @(posedge spi_sclk_o) begin
        mosi_sr  <= {mosi_sr[6:0], spi_mosi_o};
        rise_cnt <= rise_cnt + 1;
    end

    always @(posedge spi_cs_n_o) cs_rise <= cs_rise + 1;

    always @(posedge clk_i) if (bus.rx_vld) begin
        rx_log[rx_cnt[4:0]] <= bus.rx_data;
        rx_cnt <= rx_cnt + 1;
    end

    always @(negedge clk_i) begin
        if (spi_dc_o !== dc_prev && spi_sclk_o) dc_bad <= dc_bad + 1;
        dc_prev <= spi_dc_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic dc, input logic [7:0] d);
        int k = 0;
        @(negedge clk_i);
        bus.tx_vld = 1'b1; bus.tx_dc = dc; bus.tx_data = d;
        while (!bus.tx_rdy && k < 200) begin @(negedge clk_i); k++; end
        check("send_rdy", k < 200, 1);
        @(posedge clk_i); #1 bus.tx_vld = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        int k = 0;
        while (rx_cnt < target && k < 200) begin @(negedge clk_i); k++; end
        check("wait_rx", rx_cnt >= target, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!spi_cs_n_o && k < 200) begin @(negedge clk_i); k++; end
        check("wait_idle", spi_cs_n_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.tx_vld = 1'b0; bus.tx_dc = 1'b0; bus.tx_data = 8'h00;
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_cs_n", spi_cs_n_o, 1);
        check("rst_sclk", spi_sclk_o, 0);
        check("rst_mosi", spi_mosi_o, 0);
        check("rst_dc", spi_dc_o, 0);
        check("rst_rx_vld", bus.rx_vld, 0);
        check("rst_busy", busy_o, 0);
        check("rst_tx_rdy", bus.tx_rdy, 1);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // single command byte with exact cycle timing
        rise_base = rise_cnt; rx_base = rx_cnt; cs_base = cs_rise;
        @(negedge clk_i);
        bus.tx_vld = 1'b1; bus.tx_dc = 1'b0; bus.tx_data = 8'h2C;
        check("t2_cs_before", spi_cs_n_o, 1);
        @(posedge clk_i); #1 bus.tx_vld = 1'b0;
        @(negedge clk_i);
        check("t2_cs_fall", spi_cs_n_o, 0);
        check("t2_busy", busy_o, 1);
        repeat (31) @(negedge clk_i);
        check("t2_rx_vld_early", bus.rx_vld, 0);
        @(negedge clk_i);
        check("t2_rx_vld", bus.rx_vld, 1);
        check("t2_rx_data", bus.rx_data, 8'h2C);
        @(negedge clk_i);
        check("t2_rx_vld_end", bus.rx_vld, 0);
        repeat (2) @(negedge clk_i);
        check("t2_cs_gap", spi_cs_n_o, 0);
        @(negedge clk_i);
        check("t2_cs_rise", spi_cs_n_o, 1);
        check("t2_mosi_bits", mosi_sr, 8'h2C);
        check("t2_rises", rise_cnt - rise_base, 8);
        check("t2_rx_count", rx_cnt - rx_base, 1);
        check("t2_cs_rises", cs_rise - cs_base, 1);

        // three bytes back to back in one CS frame, mixing dc
        rx_base = rx_cnt; cs_base = cs_rise;
        send(1'b0, 8'h2E);
        send(1'b1, 8'h12);
        check("t3_dc_data", spi_dc_o, 1);
        send(1'b1, 8'h34);
        check("t3_cs_held", cs_rise - cs_base, 0);
        wait_rx(rx_base + 3);
        wait_idle();
        check("t3_rx0", rx_log[rx_base], 8'h2E);
        check("t3_rx1", rx_log[rx_base + 1], 8'h12);
        check("t3_rx2", rx_log[rx_base + 2], 8'h34);
        check("t3_cs_rises", cs_rise - cs_base, 1);
        check("t3_mosi_bits", mosi_sr, 8'h34);
        check("t3_dc_stable", dc_bad, 0);

        // second byte after the gap has expired: two separate frames
        rx_base = rx_cnt; cs_base = cs_rise;
        send(1'b0, 8'h81);
        wait_rx(rx_base + 1);
        repeat (7) @(negedge clk_i);
        check("t4_cs_between", spi_cs_n_o, 1);
        send(1'b1, 8'h7E);
        wait_rx(rx_base + 2);
        wait_idle();
        check("t4_rx0", rx_log[rx_base], 8'h81);
        check("t4_rx1", rx_log[rx_base + 1], 8'h7E);
        check("t4_cs_rises", cs_rise - cs_base, 2);

        // request held through a shift, data changed while not ready
        rx_base = rx_cnt;
        send(1'b0, 8'h11);
        bus.tx_vld = 1'b1; bus.tx_dc = 1'b1; bus.tx_data = 8'hA5;
        @(negedge clk_i);
        check("t5_rdy_low", bus.tx_rdy, 0);
        repeat (10) @(negedge clk_i);
        bus.tx_data = 8'h5A;
        n = 0;
        while (!bus.tx_rdy && n < 200) begin @(negedge clk_i); n++; end
        check("t5_accept_in_gap", !spi_cs_n_o && bus.tx_rdy, 1);
        @(posedge clk_i); #1 bus.tx_vld = 1'b0;
        wait_rx(rx_base + 2);
        wait_idle();
        repeat (8) @(negedge clk_i);
        check("t5_rx_once", rx_cnt - rx_base, 2);
        check("t5_rx0", rx_log[rx_base], 8'h11);
        check("t5_rx1", rx_log[rx_base + 1], 8'h5A);
        check("t5_mosi_bits", mosi_sr, 8'h5A);

        // external MISO pattern, then reset in the middle of a byte
        rx_base = rx_cnt;
        loop = 1'b0; miso_pat = 8'hF0;
        send(1'b1, 8'h00);
        wait_rx(rx_base + 1);
        wait_idle();
        check("t6_rx_miso", rx_log[rx_base], 8'hF0);
        check("t6_mosi_zero", mosi_sr, 8'h00);
        loop = 1'b1;
        rx_base = rx_cnt; rise_base = rise_cnt;
        send(1'b1, 8'hE7);
        n = 0;
        while (rise_cnt - rise_base < 3 && n < 200) begin @(negedge clk_i); n++; end
        check("t6_three_rises", rise_cnt - rise_base, 3);
        check("t6_pre_cs", spi_cs_n_o, 0);
        check("t6_pre_dc", spi_dc_o, 1);
        #2 rst_n_i = 1'b0;
        #1;
        check("t6_rst_cs_n", spi_cs_n_o, 1);
        check("t6_rst_sclk", spi_sclk_o, 0);
        check("t6_rst_mosi", spi_mosi_o, 0);
        check("t6_rst_dc", spi_dc_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_rdy", bus.tx_rdy, 1);
        check("t6_rst_rx_data", bus.rx_data, 8'h00);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        check("t6_no_rx_vld", rx_cnt - rx_base, 0);
        send(1'b0, 8'h2B);
        wait_rx(rx_base + 1);
        wait_idle();
        check("t6_rx_after", rx_log[rx_base], 8'h2B);
        check("t6_mosi_after", mosi_sr, 8'h2B);
        check("t6_rx_count", rx_cnt - rx_base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
